// File: rtl/gray_updown_counter.sv
// Gray-code up/down counter.
// The count is held as a binary register; the Gray view is registered in
// parallel, so both outputs come straight from flops and stay in lockstep.
// WRAP selects modulo wrap-around or saturation at the end of the range.
// tc pulses for one cycle after a wrap edge (WRAP=1) or after the edge that
// brings the count onto the limit in the stepping direction (WRAP=0).

module gray_updown_counter #(
  parameter int WIDTH = 4,
  parameter int WRAP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             tc,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] NEAR_MAX = MAX_VAL - ONE;
  localparam bit               SAT     = (WRAP == 0);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             tc_q;

  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic             tc_d;
  logic [WIDTH-1:0] load_bin;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (bin_q == MAX_VAL);
  assign at_zero = (bin_q == '0);

  // Gray-to-binary of the load value: each binary bit is the XOR of all
  // Gray bits at and above it, accumulated from the MSB down.
  always_comb begin : load_decode
    logic acc;
    acc      = 1'b0;
    load_bin = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc         = acc ^ load_val[i];
      load_bin[i] = acc;
    end
  end

  // Next count and terminal-count flag; priority is clear, then load, then en.
  always_comb begin
    bin_d = bin_q;
    tc_d  = 1'b0;
    if (clear) begin
      bin_d = '0;
    end else if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (!dir) begin
        if (at_max) begin
          // Saturating mode blocks the step and stays silent.
          if (!SAT) begin
            bin_d = '0;
            tc_d  = 1'b1;
          end
        end else begin
          bin_d = bin_q + ONE;
          tc_d  = SAT && (bin_q == NEAR_MAX);
        end
      end else begin
        if (at_zero) begin
          if (!SAT) begin
            bin_d = MAX_VAL;
            tc_d  = 1'b1;
          end
        end else begin
          bin_d = bin_q - ONE;
          tc_d  = SAT && (bin_q == ONE);
        end
      end
    end
  end

  // Gray view of the next count, registered alongside the binary value.
  always_comb begin
    gray_d = bin_d ^ (bin_d >> 1);
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end

  assign gray_out = gray_q;
  assign bin_out  = bin_q;
  assign tc       = tc_q;

  // End-of-range indication only exists in saturating mode.
  assign at_limit = SAT && (dir ? at_zero : at_max);

endmodule
